// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: K28.5 comma encodings, the 10-bit symbol type
// and the receive aligner state encoding.
package pcie_phy_pkg;

    typedef logic [9:0] symbol_t;

    localparam symbol_t K28_5_RDN = 10'h17C;
    localparam symbol_t K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CANDIDATE,
        ST_LOCKED
    } align_state_t;

endpackage

// File: rtl/pcie_comma_detect.sv
// Combinational K28.5 (COM) match on a 10-bit window, either running disparity.
module pcie_comma_detect
    import pcie_phy_pkg::*;
(
    input  symbol_t symbol,
    output logic    match
);

    assign match = (symbol == K28_5_RDN) || (symbol == K28_5_RDP);

endmodule

// File: rtl/pcie_rx_symbol_aligner.sv
// Single-lane 8b/10b receive symbol aligner: finds the COM comma in the serial
// bit stream, locks the 10-bit boundary and emits one aligned symbol per boundary.
module pcie_rx_symbol_aligner
    import pcie_phy_pkg::*;
#(
    parameter int LOCK_COMMAS   = 2,
    parameter int UNLOCK_ERRORS = 4,
    parameter int COMMA_TIMEOUT = 1538
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    lane_en_i,
    input  logic    serial_bit_i,
    input  logic    serial_bit_valid_i,
    output symbol_t symbol_o,
    output logic    symbol_valid_o,
    output logic    is_comma_o,
    output logic    locked_o
);

    localparam int TW = $clog2(COMMA_TIMEOUT + 1);

    align_state_t  state, state_next;
    logic [8:0]    history, history_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [2:0]    comma_cnt, comma_cnt_next;
    logic [3:0]    misalign_cnt, misalign_cnt_next;
    logic [TW-1:0] timeout_cnt, timeout_cnt_next;
    symbol_t       window;
    logic          comma_hit;
    logic          boundary;
    logic          emit;

    // w[0] is shifted out by the next valid bit before anything reads it, so only
    // w[9:1] is stored; the updated window is the new bit on top of that history.
    assign window   = {serial_bit_i, history};
    assign boundary = (bit_cnt == 4'd9);
    assign locked_o = (state == ST_LOCKED);

    pcie_comma_detect u_comma_detect (
        .symbol (window),
        .match  (comma_hit)
    );

    always_comb begin
        state_next        = state;
        history_next      = history;
        bit_cnt_next      = bit_cnt;
        comma_cnt_next    = comma_cnt;
        misalign_cnt_next = misalign_cnt;
        timeout_cnt_next  = timeout_cnt;
        emit              = 1'b0;

        if (!lane_en_i) begin
            state_next        = ST_UNLOCKED;
            bit_cnt_next      = '0;
            comma_cnt_next    = '0;
            misalign_cnt_next = '0;
            timeout_cnt_next  = '0;
        end else if (serial_bit_valid_i) begin
            history_next = window[9:1];
            bit_cnt_next = boundary ? 4'd0 : bit_cnt + 4'd1;

            case (state)
                ST_UNLOCKED: begin
                    if (comma_hit) begin
                        bit_cnt_next   = '0;
                        comma_cnt_next = 3'd1;
                        if (LOCK_COMMAS == 1) begin
                            state_next = ST_LOCKED;
                            emit       = 1'b1;
                        end else begin
                            state_next = ST_CANDIDATE;
                        end
                    end
                end
                ST_CANDIDATE: begin
                    if (comma_hit && boundary) begin
                        comma_cnt_next = comma_cnt + 3'd1;
                        if (int'(comma_cnt) + 1 >= LOCK_COMMAS) begin
                            state_next = ST_LOCKED;
                            emit       = 1'b1;
                        end
                    end else if (comma_hit) begin
                        bit_cnt_next   = '0;
                        comma_cnt_next = 3'd1;
                    end
                end
                ST_LOCKED: begin
                    // Unlocking still lets the current symbol out; counters restart from zero.
                    if (boundary) begin
                        emit = 1'b1;
                        if (comma_hit) begin
                            misalign_cnt_next = '0;
                            timeout_cnt_next  = '0;
                        end else if (int'(timeout_cnt) + 1 >= COMMA_TIMEOUT) begin
                            state_next        = ST_UNLOCKED;
                            comma_cnt_next    = '0;
                            misalign_cnt_next = '0;
                            timeout_cnt_next  = '0;
                        end else begin
                            timeout_cnt_next = timeout_cnt + TW'(1);
                        end
                    end else if (comma_hit) begin
                        if (int'(misalign_cnt) + 1 >= UNLOCK_ERRORS) begin
                            state_next        = ST_UNLOCKED;
                            comma_cnt_next    = '0;
                            misalign_cnt_next = '0;
                            timeout_cnt_next  = '0;
                        end else begin
                            misalign_cnt_next = misalign_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_UNLOCKED;
            history        <= '0;
            bit_cnt        <= '0;
            comma_cnt      <= '0;
            misalign_cnt   <= '0;
            timeout_cnt    <= '0;
            symbol_o       <= '0;
            symbol_valid_o <= 1'b0;
            is_comma_o     <= 1'b0;
        end else begin
            state          <= state_next;
            history        <= history_next;
            bit_cnt        <= bit_cnt_next;
            comma_cnt      <= comma_cnt_next;
            misalign_cnt   <= misalign_cnt_next;
            timeout_cnt    <= timeout_cnt_next;
            symbol_valid_o <= emit;
            if (emit) begin
                symbol_o   <= window;
                is_comma_o <= comma_hit;
            end
        end
    end

endmodule

// File: tb/tb_pcie_rx_symbol_aligner.sv
// Self-checking bench for pcie_rx_symbol_aligner: table-driven lock/gap vectors
// plus hand-written misalignment, timeout and lane-enable sequences, scoreboarded.
module tb_pcie_rx_symbol_aligner;
    import pcie_phy_pkg::*;

    logic    clk_i = 1'b0;
    logic    rst_i;
    logic    lane_en_i;
    logic    serial_bit_i;
    logic    serial_bit_valid_i;
    symbol_t symbol_o;
    logic    symbol_valid_o;
    logic    is_comma_o;
    logic    locked_o;

    typedef struct {
        symbol_t sym;
        logic    comma;
        logic    locked;
        int      edge_num;
    } expect_t;

    typedef struct {
        symbol_t sym;
        logic    strobe;
        logic    comma;
        logic    locked;
        logic    gaps;
    } vector_t;

    expect_t sb[$];
    vector_t vectors[8];
    int      checks = 0;
    int      errors = 0;
    int      cycle_count = 0;

    always #5 clk_i = ~clk_i;

    pcie_rx_symbol_aligner #(
        .LOCK_COMMAS   (2),
        .UNLOCK_ERRORS (4),
        .COMMA_TIMEOUT (8)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .lane_en_i          (lane_en_i),
        .serial_bit_i       (serial_bit_i),
        .serial_bit_valid_i (serial_bit_valid_i),
        .symbol_o           (symbol_o),
        .symbol_valid_o     (symbol_valid_o),
        .is_comma_o         (is_comma_o),
        .locked_o           (locked_o)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_i);
        serial_bit_i       = b;
        serial_bit_valid_i = 1'b1;
        @(posedge clk_i);
        #1 serial_bit_valid_i = 1'b0;
    endtask

    // Sends one symbol LSB ('a') first; a strobe is expected on the edge sampling bit 'j'.
    task automatic apply_stimulus(input symbol_t sym, input logic strobe, input logic comma,
                                  input logic locked, input logic gaps);
        expect_t e;
        int      n;
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(negedge clk_i);
                    serial_bit_i       = 1'($urandom);
                    serial_bit_valid_i = 1'b0;
                end
            end
            @(negedge clk_i);
            serial_bit_i       = sym[i];
            serial_bit_valid_i = 1'b1;
            if (i == 9 && strobe) begin
                e.sym      = sym;
                e.comma    = comma;
                e.locked   = locked;
                e.edge_num = cycle_count + 1;
                sb.push_back(e);
            end
            @(posedge clk_i);
            #1 serial_bit_valid_i = 1'b0;
        end
    endtask

    // One comma shifted by a single bit: these two symbols carry exactly the
    // bit stream "0, K28.5(17C), 101010101" across two aligned boundaries.
    task automatic misaligned_comma(input logic second_strobe);
        apply_stimulus(10'h2F8, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(10'h2AA, second_strobe, 1'b0, 1'b1, 1'b0);
    endtask

    always begin : monitor
        expect_t e;
        @(posedge clk_i);
        cycle_count++;
        #1;
        if (symbol_valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: got symbol 0x%0h at edge %0d, expected no strobe",
                         symbol_o, cycle_count);
            end else begin
                e = sb.pop_front();
                if (symbol_o !== e.sym || is_comma_o !== e.comma || locked_o !== e.locked
                    || cycle_count != e.edge_num) begin
                    errors++;
                    $display("[TB] FAIL strobe: got sym=0x%0h comma=%b locked=%b edge=%0d, expected sym=0x%0h comma=%b locked=%b edge=%0d",
                             symbol_o, is_comma_o, locked_o, cycle_count,
                             e.sym, e.comma, e.locked, e.edge_num);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i              = 1'b1;
        lane_en_i          = 1'b1;
        serial_bit_i       = 1'b0;
        serial_bit_valid_i = 1'b0;

        vectors[0] = '{10'h17C, 1'b0, 1'b1, 1'b0, 1'b0};
        vectors[1] = '{10'h1B5, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors[2] = '{10'h283, 1'b1, 1'b1, 1'b1, 1'b0};
        vectors[3] = '{10'h2A6, 1'b1, 1'b0, 1'b1, 1'b0};
        vectors[4] = '{10'h2AA, 1'b1, 1'b0, 1'b1, 1'b1};
        vectors[5] = '{10'h17C, 1'b1, 1'b1, 1'b1, 1'b1};
        vectors[6] = '{10'h155, 1'b1, 1'b0, 1'b1, 1'b1};
        vectors[7] = '{10'h1B5, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset held with random valid bits on the wire.
        repeat (3) begin
            @(negedge clk_i);
            serial_bit_i       = 1'($urandom);
            serial_bit_valid_i = 1'b1;
        end
        @(posedge clk_i);
        #2;
        check_output("reset_symbol", symbol_o, 10'h000);
        check_output("reset_valid", symbol_valid_o, 1'b0);
        check_output("reset_comma", is_comma_o, 1'b0);
        check_output("reset_locked", locked_o, 1'b0);
        @(negedge clk_i);
        rst_i              = 1'b0;
        serial_bit_valid_i = 1'b0;

        for (int i = 0; i < 20; i++) send_bit(1'(i));
        check_output("no_lock_without_comma", locked_o, 1'b0);

        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vectors[i].sym, vectors[i].strobe, vectors[i].comma,
                           vectors[i].locked, vectors[i].gaps);
            check_output($sformatf("locked_after_vec%0d", i), locked_o, vectors[i].locked);
        end

        // Misaligned commas: three, then an aligned comma clears the count, then four.
        apply_stimulus(10'h17C, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            misaligned_comma(1'b1);
            check_output($sformatf("locked_misalign_a%0d", i + 1), locked_o, 1'b1);
        end
        apply_stimulus(10'h17C, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            misaligned_comma(1'b1);
            check_output($sformatf("locked_misalign_b%0d", i + 1), locked_o, 1'b1);
        end
        apply_stimulus(10'h17C, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) misaligned_comma(1'b1);
        check_output("locked_before_4th_misalign", locked_o, 1'b1);
        misaligned_comma(1'b0);
        check_output("unlocked_after_4th_misalign", locked_o, 1'b0);

        // Relock, then eight non-comma symbols hit the timeout on the eighth.
        apply_stimulus(10'h17C, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(10'h283, 1'b1, 1'b1, 1'b1, 1'b0);
        check_output("relock_for_timeout", locked_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus((i % 2 == 0) ? 10'h2A6 : 10'h155, 1'b1, 1'b0, (i < 7), 1'b0);
        end
        check_output("unlocked_after_timeout", locked_o, 1'b0);
        apply_stimulus(10'h155, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("no_strobe_after_timeout", locked_o, 1'b0);

        // Lane disable in the middle of a symbol while locked.
        apply_stimulus(10'h17C, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(10'h283, 1'b1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(10'h2A6, 1'b1, 1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk_i);
        lane_en_i          = 1'b0;
        serial_bit_i       = 1'b1;
        serial_bit_valid_i = 1'b1;
        @(posedge clk_i);
        #2;
        check_output("lane_off_locked", locked_o, 1'b0);
        check_output("lane_off_valid", symbol_valid_o, 1'b0);
        repeat (4) @(negedge clk_i);
        serial_bit_valid_i = 1'b0;
        lane_en_i          = 1'b1;
        apply_stimulus(10'h17C, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("lane_on_candidate", locked_o, 1'b0);
        apply_stimulus(10'h283, 1'b1, 1'b1, 1'b1, 1'b0);
        check_output("lane_on_relock", locked_o, 1'b1);
        apply_stimulus(10'h2AA, 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (4) @(posedge clk_i);
        #2;
        check_output("missed_strobes", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
